// File: rtl/uart_rx_ext_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_ext_pkg
//  Definitions shared by the UART receive path (and the matching TX):
//  - FSM state encodings (3 bits, legacy-compatible constants)
//  - UART_IDLE_LVL : logic level of an idle line
//  - params_ok()   : legal-range check for the receiver parameters
// ---------------------------------------------------------------------------
package uart_rx_ext_pkg;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE   = 3'd0;
   localparam state_t S_START  = 3'd1;
   localparam state_t S_DATA   = 3'd2;
   localparam state_t S_PARITY = 3'd3;
   localparam state_t S_STOP   = 3'd4;
   localparam state_t S_DONE   = 3'd5;
   localparam state_t S_BREAK  = 3'd6;

   localparam logic UART_IDLE_LVL = 1'b1;

   // The mid-bit sample point needs at least a few clocks per bit to land
   // clear of the edges; data/stop/parity widths follow the UART framing rules.
   function automatic bit params_ok(input int cpb, input int data_bits,
                                    input int stop_bits, input int parity_odd);
      return (cpb >= 4) && (data_bits >= 5) && (data_bits <= 9) &&
             (stop_bits >= 1) && (stop_bits <= 2) &&
             (parity_odd >= 0) && (parity_odd <= 1);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
//  Two-flop synchroniser for the asynchronous UART line.
//  Ports:
//   clk      in  system clock
//   rst      in  synchronous reset, active-high (both stages go to idle level)
//   async_in in  raw serial line
//   sync_out out line value retimed into the clk domain (2 clk latency)
// ---------------------------------------------------------------------------
module uart_rx_sync
   import uart_rx_ext_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic sync_out
);

   logic meta;

   // NOTE: reset to the idle level, not 0, so leaving reset never looks like
   // a falling start edge to the receiver.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta     <= UART_IDLE_LVL;
         sync_out <= UART_IDLE_LVL;
      end else begin
         meta     <= async_in;
         sync_out <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_ext.sv
// ---------------------------------------------------------------------------
// uart_rx_ext
//  Parametrised UART receiver: 5..9 data bits LSB-first, 1 or 2 stop bits,
//  optional parity. Each word is held on data_out until data_ack.
//  Optional feature macro: UART_RX_PARITY_EN (one parity bit after the data;
//  parity_err reported per PARITY_ODD). Without it parity_err is always 0.
//  Ports:
//   clk         in   system clock
//   rst         in   synchronous reset, active-high
//   serial_rx   in   asynchronous UART line, idle high
//   data_ack    in   consumer has taken data_out
//   data_out    out  received word (DATA_BITS)
//   data_valid  out  data_out/status valid; held until data_ack
//   frame_err   out  a stop bit sampled low (qualified by data_valid)
//   parity_err  out  parity mismatch (qualified by data_valid)
//   overrun_err out  1-cycle pulse: frame completed while a word was pending
// ---------------------------------------------------------------------------
module uart_rx_ext
   import uart_rx_ext_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 serial_rx,
   input  logic                 data_ack,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun_err
);

   if (!params_ok(CLKS_PER_BIT, DATA_BITS, STOP_BITS, PARITY_ODD)) begin : g_bad_params
      $error("uart_rx_ext: parameter out of range");
   end

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);

   localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_TERM = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

   logic                 rx_s;
   state_t               state;
   logic [CW-1:0]        cnt;
   logic [BW-1:0]        bit_idx;
   logic                 stop_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 frame_bad;
   logic                 parity_bad;

   uart_rx_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (serial_rx),
      .sync_out (rx_s)
   );

   // NOTE: all state here is sequential and uses non-blocking assignments, so
   // every branch reads the pre-edge value of cnt/state/data_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         stop_idx    <= 1'b0;
         shreg       <= '0;
         frame_bad   <= 1'b0;
         parity_bad  <= 1'b0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         frame_err   <= 1'b0;
         parity_err  <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         overrun_err <= 1'b0;
         if (data_valid && data_ack)
            data_valid <= 1'b0;

         // Free-running bit timer; states that need a fresh phase clear it.
         cnt <= (cnt == CNT_TERM) ? '0 : cnt + 1'b1;

         case (state)
            S_IDLE: begin
               cnt        <= '0;
               bit_idx    <= '0;
               stop_idx   <= 1'b0;
               frame_bad  <= 1'b0;
               parity_bad <= 1'b0;
               if (!rx_s)
                  state <= S_START;
            end

            // Re-check the start bit at its middle; from here on the
            // terminal count lands mid-bit.
            S_START: begin
               if (cnt == CNT_MID) begin
                  cnt   <= '0;
                  state <= rx_s ? S_IDLE : S_DATA;
               end
            end

            S_DATA: begin
               if (cnt == CNT_TERM) begin
                  shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                  if (bit_idx == BIT_LAST) begin
                     bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                     state   <= S_PARITY;
`else
                     state   <= S_STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (cnt == CNT_TERM) begin
                  parity_bad <= ((^shreg) ^ rx_s) != PARITY_ODD[0];
                  state      <= S_STOP;
               end
            end
`endif

            S_STOP: begin
               if (cnt == CNT_TERM) begin
                  if (!rx_s)
                     frame_bad <= 1'b1;
                  if (stop_idx == STOP_LAST)
                     state <= S_DONE;
                  else
                     stop_idx <= stop_idx + 1'b1;
               end
            end

            // A pending, unacknowledged word wins: the new one is dropped.
            S_DONE: begin
               if (!data_valid || data_ack) begin
                  data_out   <= shreg;
                  frame_err  <= frame_bad;
                  parity_err <= parity_bad;
                  data_valid <= 1'b1;
               end else begin
                  overrun_err <= 1'b1;
               end
               state <= frame_bad ? S_BREAK : S_IDLE;
            end

            // Line held low past the stop bit: wait for it to return idle so
            // the break is not mistaken for a new start bit.
            S_BREAK: begin
               if (rx_s)
                  state <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_ext.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ext
//  Scoreboard bench for uart_rx_ext (CLKS_PER_BIT=10, 8 data bits, 1 stop).
//  Stimulus pushes expected words into exp_q; the monitor pops and compares
//  whenever the DUT presents a new word. Honours UART_RX_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_uart_rx_ext;

   localparam int CPB = 10;
   localparam int DW  = 8;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   typedef struct packed {
      logic [DW-1:0] data;
      logic          fe;
      logic          pe;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          serial_rx = 1'b1;
   logic          data_ack = 1'b0;
   logic [DW-1:0] data_out;
   logic          data_valid;
   logic          frame_err;
   logic          parity_err;
   logic          overrun_err;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   rx_count = 0;
   int   overrun_cnt = 0;
   bit   auto_ack = 1'b1;
   bit   ack_once = 1'b0;

   always #4 clk = ~clk;

   uart_rx_ext #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (DW),
      .STOP_BITS    (1),
      .PARITY_ODD   (0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .serial_rx   (serial_rx),
      .data_ack    (data_ack),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .frame_err   (frame_err),
      .parity_err  (parity_err),
      .overrun_err (overrun_err)
   );

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic expect_word(input logic [DW-1:0] d, input logic fe, input logic pe);
      exp_t e;
      e.data = d;
      e.fe   = fe;
      e.pe   = pe;
      exp_q.push_back(e);
   endtask

   task automatic hold_line(input logic lvl, input int bits);
      serial_rx = lvl;
      repeat (bits * CPB) @(negedge clk);
   endtask

   // Start bit, data LSB-first, optional even-parity bit (par_flip corrupts
   // it), one stop bit of level stop_val.
   task automatic send_frame(input logic [DW-1:0] d, input logic stop_val,
                             input logic par_flip);
      hold_line(1'b0, 1);
      for (int i = 0; i < DW; i++)
         hold_line(d[i], 1);
      if (PAR_EN)
         hold_line((^d) ^ par_flip, 1);
      hold_line(stop_val, 1);
   endtask

   task automatic wait_words(input int n, input string name);
      for (int i = 0; i < 40 * CPB && rx_count < n; i++)
         @(negedge clk);
      check(name, rx_count, n);
   endtask

   // Monitor: compare each newly presented word, drive data_ack.
   initial begin : monitor
      bit   fresh;
      exp_t e;
      fresh = 1'b1;
      forever begin
         @(negedge clk);
         if (overrun_err)
            overrun_cnt++;
         if (data_valid && fresh) begin
            rx_count++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got %h expected none", data_out);
            end else begin
               e = exp_q.pop_front();
               check("word", {22'd0, data_out, frame_err, parity_err},
                     {22'd0, e.data, e.fe, e.pe});
            end
         end
         data_ack = data_valid && (auto_ack || ack_once);
         if (data_ack)
            ack_once = 1'b0;
         fresh = !data_valid || data_ack;
      end
   end

   initial begin : stimulus
      int base;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_data_out", data_out, 0);
      check("rst_valid", data_valid, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_parity_err", parity_err, 0);
      check("rst_overrun", overrun_err, 0);
      rst = 1'b0;
      hold_line(1'b1, 2);

      // 1: single word 0xA1, held until ack, cleared the cycle after ack
      auto_ack = 1'b0;
      expect_word(8'hA1, 1'b0, 1'b0);
      send_frame(8'hA1, 1'b1, 1'b0);
      wait_words(1, "t1_arrive");
      repeat (5) @(negedge clk);
      check("t1_valid_held", data_valid, 1);
      @(posedge clk);
      ack_once = 1'b1;
      @(negedge clk);
      check("t1_valid_before_ack_edge", data_valid, 1);
      @(negedge clk);
      check("t1_ack_clears", data_valid, 0);
      auto_ack = 1'b1;
      hold_line(1'b1, 1);

      // 2: back-to-back 0xA1, 0x80, each acknowledged
      base = overrun_cnt;
      expect_word(8'hA1, 1'b0, 1'b0);
      expect_word(8'h80, 1'b0, 1'b0);
      send_frame(8'hA1, 1'b1, 1'b0);
      send_frame(8'h80, 1'b1, 1'b0);
      wait_words(3, "t2_arrive");
      check("t2_no_overrun", overrun_cnt - base, 0);
      hold_line(1'b1, 1);

      // 3: 3-clk glitch is rejected, next frame 0x55 is clean
      serial_rx = 1'b0;
      repeat (3) @(negedge clk);
      hold_line(1'b1, 2);
      check("t3_glitch_ignored", rx_count, 3);
      expect_word(8'h55, 1'b0, 1'b0);
      send_frame(8'h55, 1'b1, 1'b0);
      wait_words(4, "t3_arrive");
      hold_line(1'b1, 1);

      // 4: 0x3C with low stop bit, line low one more bit, then recovery
      expect_word(8'h3C, 1'b1, 1'b0);
      send_frame(8'h3C, 1'b0, 1'b0);
      hold_line(1'b0, 1);
      hold_line(1'b1, 2);
      wait_words(5, "t4_arrive");
      expect_word(8'hC3, 1'b0, 1'b0);
      send_frame(8'hC3, 1'b1, 1'b0);
      wait_words(6, "t4_after_break");
      hold_line(1'b1, 1);

      // 5: 0x11 then 0x22 with no ack: overrun pulse, 0x11 kept
      auto_ack = 1'b0;
      base = overrun_cnt;
      expect_word(8'h11, 1'b0, 1'b0);
      send_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0);
      hold_line(1'b1, 1);
      check("t5_overrun_pulses", overrun_cnt - base, 1);
      check("t5_data_kept", data_out, 8'h11);
      check("t5_valid_still", data_valid, 1);
      auto_ack = 1'b1;
      repeat (3) @(negedge clk);
      check("t5_acked", data_valid, 0);

      // 6: reset in the middle of 0xFF's data bits
      hold_line(1'b0, 1);
      hold_line(1'b1, 3);
      rst = 1'b1;
      @(negedge clk);
      check("t6_rst_data_out", data_out, 0);
      check("t6_rst_valid", data_valid, 0);
      rst = 1'b0;
      hold_line(1'b1, 8);
      check("t6_no_word", rx_count, 7);
      expect_word(8'h0F, 1'b0, 1'b0);
      send_frame(8'h0F, 1'b1, 1'b0);
      wait_words(8, "t6_arrive");
      hold_line(1'b1, 1);

      // Parity: a corrupted parity bit is flagged, a correct one is not
      if (PAR_EN) begin
         expect_word(8'hA1, 1'b0, 1'b1);
         send_frame(8'hA1, 1'b1, 1'b1);
         wait_words(9, "par_bad_arrive");
         hold_line(1'b1, 1);
         expect_word(8'hA1, 1'b0, 1'b0);
         send_frame(8'hA1, 1'b1, 1'b0);
         wait_words(10, "par_good_arrive");
         hold_line(1'b1, 1);
      end

      check("queue_drained", exp_q.size(), 0);
      check("total_overruns", overrun_cnt, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
